// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the multi-channel pushbutton debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHold   = 2'd1,
        StRepeat = 2'd2
    } rpt_state_e;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-flop synchroniser, tick-based debounce, edge pulses, hold-to-repeat FSM.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned DB_TICKS         = 5,
    parameter int unsigned RPT_DELAY_TICKS  = 500,
    parameter int unsigned RPT_PERIOD_TICKS = 100,
    parameter bit          RESET_VAL        = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic pbtn_i,
    input  logic rpt_en_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o,
    output logic rpt_o
);

    localparam int unsigned DbW    = cnt_width(DB_TICKS);
    localparam int unsigned RptMax = (RPT_DELAY_TICKS > RPT_PERIOD_TICKS) ?
                                     RPT_DELAY_TICKS : RPT_PERIOD_TICKS;
    localparam int unsigned RptW   = cnt_width(RptMax);

    localparam logic [DbW-1:0]  DbLast  = DbW'(DB_TICKS - 1);
    localparam logic [RptW-1:0] DlyLast = RptW'(RPT_DELAY_TICKS - 1);
    localparam logic [RptW-1:0] PerLast = RptW'(RPT_PERIOD_TICKS - 1);

    logic            sync1_q, sync2_q;
    logic            db_q, db_d;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic            rise_q, rise_d, fall_q, fall_d, rpt_q, rpt_d;
    logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
    rpt_state_e      state_q, state_d;

    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q == db_q) begin
            db_cnt_d = '0;
        end else if (tick_i) begin
            if (db_cnt_q == DbLast) begin
                db_d     = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end
        rise_d = db_d & ~db_q;
        fall_d = ~db_d & db_q;
    end

    // Release or disable wins over a repeat that falls due on the same edge.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        rpt_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (rise_d && rpt_en_i) begin
                    state_d   = StHold;
                    rpt_cnt_d = '0;
                end
            end
            StHold: begin
                if (fall_d || !rpt_en_i) begin
                    state_d   = StIdle;
                    rpt_cnt_d = '0;
                end else if (tick_i) begin
                    if (rpt_cnt_q == DlyLast) begin
                        rpt_d     = 1'b1;
                        state_d   = StRepeat;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RptW'(1);
                    end
                end
            end
            StRepeat: begin
                if (fall_d || !rpt_en_i) begin
                    state_d   = StIdle;
                    rpt_cnt_d = '0;
                end else if (tick_i) begin
                    if (rpt_cnt_q == PerLast) begin
                        rpt_d     = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RptW'(1);
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                rpt_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= RESET_VAL;
            sync2_q   <= RESET_VAL;
            db_q      <= RESET_VAL;
            db_cnt_q  <= '0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            rpt_q     <= 1'b0;
            rpt_cnt_q <= '0;
            state_q   <= StIdle;
        end else begin
            sync1_q   <= pbtn_i;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_cnt_q  <= db_cnt_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            rpt_q     <= rpt_d;
            rpt_cnt_q <= rpt_cnt_d;
            state_q   <= state_d;
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign rpt_o  = rpt_q;

endmodule

// File: rtl/debounce_ar.sv
// N-channel pushbutton debouncer: shared tick generator feeding one debounce_chan per button.
module debounce_ar
    import debounce_pkg::*;
#(
    parameter int unsigned         NUM_BTNS         = 6,
    parameter int unsigned         TICK_CYCLES      = 100000,
    parameter int unsigned         DB_TICKS         = 5,
    parameter int unsigned         RPT_DELAY_TICKS  = 500,
    parameter int unsigned         RPT_PERIOD_TICKS = 100,
    parameter logic [NUM_BTNS-1:0] RESET_VAL        = NUM_BTNS'(1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] pbtn_in,
    input  logic [NUM_BTNS-1:0] rpt_en,
    output logic [NUM_BTNS-1:0] pbtn_db,
    output logic [NUM_BTNS-1:0] rise,
    output logic [NUM_BTNS-1:0] fall,
    output logic [NUM_BTNS-1:0] rpt
);

    if (TICK_CYCLES < 2) begin : g_bad_tick_cycles
        $error("debounce_ar: TICK_CYCLES must be >= 2");
    end
    if (DB_TICKS < 1 || RPT_DELAY_TICKS < 1 || RPT_PERIOD_TICKS < 1) begin : g_bad_ticks
        $error("debounce_ar: all *_TICKS parameters must be >= 1");
    end

    localparam int unsigned        TickW    = cnt_width(TICK_CYCLES - 1);
    localparam logic [TickW-1:0]   TickLast = TickW'(TICK_CYCLES - 1);

    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick;

    always_comb begin
        tick       = (tick_cnt_q == TickLast);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar i = 0; i < int'(NUM_BTNS); i++) begin : g_chan
        debounce_chan #(
            .DB_TICKS         (DB_TICKS),
            .RPT_DELAY_TICKS  (RPT_DELAY_TICKS),
            .RPT_PERIOD_TICKS (RPT_PERIOD_TICKS),
            .RESET_VAL        (RESET_VAL[i])
        ) u_chan (
            .clk_i    (clk),
            .rst_ni   (reset),
            .tick_i   (tick),
            .pbtn_i   (pbtn_in[i]),
            .rpt_en_i (rpt_en[i]),
            .db_o     (pbtn_db[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i]),
            .rpt_o    (rpt[i])
        );
    end

endmodule

// File: tb/tb_debounce_ar.sv
// Scenario bench for debounce_ar with a cycle-indexed arithmetic reference model.
module tb_debounce_ar;

    localparam int N   = 6;
    localparam int TC  = 4;
    localparam int DB  = 3;
    localparam int DLY = 5;
    localparam int PER = 2;
    localparam logic [N-1:0] RV = 6'b000001;

    logic         clk;
    logic         rst_n = 1'b0;
    logic [N-1:0] pbtn_in = RV;
    logic [N-1:0] rpt_en = '0;
    logic [N-1:0] pbtn_db, rise, fall, rpt;

    int tests_run = 0;
    int fails = 0;

    debounce_ar #(
        .NUM_BTNS         (N),
        .TICK_CYCLES      (TC),
        .DB_TICKS         (DB),
        .RPT_DELAY_TICKS  (DLY),
        .RPT_PERIOD_TICKS (PER),
        .RESET_VAL        (RV)
    ) dut (
        .clk     (clk),
        .reset   (rst_n),
        .pbtn_in (pbtn_in),
        .rpt_en  (rpt_en),
        .pbtn_db (pbtn_db),
        .rise    (rise),
        .fall    (fall),
        .rpt     (rpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. Edge e counts clock edges since reset release; tick edges are multiples
    // of TC. A level flips at the tick edge completing DB ticks since it last agreed with the
    // input seen two edges earlier. Repeats fire at tick counts DLY, DLY+PER, ... after arming.
    logic [N-1:0] m_db, m_rise, m_fall, m_rpt, m_sync;
    logic [N-1:0] in_q[$];
    int           e;
    int           last_eq[N];
    bit           armed[N];
    int           arm_edge[N];
    bit           m_tick;
    int           m_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e = 0;
            m_db = RV;
            m_rise = '0;
            m_fall = '0;
            m_rpt = '0;
            in_q = {};
            for (int c = 0; c < N; c++) begin
                last_eq[c] = 0;
                armed[c] = 0;
                arm_edge[c] = 0;
            end
        end else begin
            e++;
            m_tick = (e % TC == 0);
            m_sync = (in_q.size() >= 2) ? in_q[1] : RV;
            in_q.push_front(pbtn_in);
            if (in_q.size() > 3) void'(in_q.pop_back());
            m_rise = '0;
            m_fall = '0;
            m_rpt = '0;
            for (int c = 0; c < N; c++) begin
                if (m_sync[c] == m_db[c]) begin
                    last_eq[c] = e;
                end else if (m_tick && (e / TC - last_eq[c] / TC) == DB) begin
                    m_db[c] = m_sync[c];
                    m_rise[c] = m_sync[c];
                    m_fall[c] = ~m_sync[c];
                    last_eq[c] = e;
                end
                if (armed[c]) begin
                    if (m_fall[c] || !rpt_en[c]) begin
                        armed[c] = 0;
                    end else if (m_tick) begin
                        m_n = e / TC - arm_edge[c] / TC;
                        if (m_n == DLY || (m_n > DLY && (m_n - DLY) % PER == 0)) m_rpt[c] = 1'b1;
                    end
                end
                if (m_rise[c] && rpt_en[c]) begin
                    armed[c] = 1;
                    arm_edge[c] = e;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pbtn_in = RV;
        rpt_en = '0;
        repeat (3) step();
        tests_run++;
        if ({pbtn_db, rise, fall, rpt} !== {RV, 18'b0}) begin
            fails++;
            $display("FAIL reset_hold: got db=%b r=%b f=%b p=%b want db=%b r=f=p=0",
                     pbtn_db, rise, fall, rpt, RV);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            tests_run++;
            if (pbtn_db !== RV || (rise | fall | rpt) !== '0) begin
                fails++;
                $display("FAIL reset_idle: cyc %0d got db=%b r=%b f=%b p=%b want db=%b quiet",
                         i, pbtn_db, rise, fall, rpt, RV);
            end
        end
    endtask

    task automatic test_debounce_rise();
        int lat = 0;
        bit got = 0;
        repeat ($urandom_range(0, 3)) step();
        pbtn_in[1] = 1'b1;
        for (int i = 1; i <= 30 && !got; i++) begin
            step();
            tests_run++;
            if ({pbtn_db, rise, fall, rpt} !== {m_db, m_rise, m_fall, m_rpt}) begin
                fails++;
                $display("FAIL model_rise: got %b/%b/%b/%b want %b/%b/%b/%b",
                         pbtn_db, rise, fall, rpt, m_db, m_rise, m_fall, m_rpt);
            end
            if (pbtn_db[1]) begin
                got = 1;
                lat = i;
                tests_run++;
                if (rise[1] !== 1'b1) begin
                    fails++;
                    $display("FAIL rise_same_cycle: got rise[1]=%b want 1", rise[1]);
                end
            end
        end
        tests_run++;
        if (!got || lat < 11 || lat > 14) begin
            fails++;
            $display("FAIL db_latency: got %0d cycles (seen=%0d) want 11..14", lat, got);
        end
        step();
        tests_run++;
        if (rise[1] !== 1'b0) begin
            fails++;
            $display("FAIL rise_width: got rise[1]=%b one cycle later want 0", rise[1]);
        end
        pbtn_in[1] = 1'b0;
        repeat (20) step();
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 6; j++) begin
                pbtn_in[2] = (j < 3);
                step();
                tests_run++;
                if (pbtn_db[2] !== 1'b0 || rise[2] !== 1'b0 ||
                    {pbtn_db, rise, fall, rpt} !== {m_db, m_rise, m_fall, m_rpt}) begin
                    fails++;
                    $display("FAIL glitch: got %b/%b/%b/%b want %b/%b/%b/%b (db[2]=0)",
                             pbtn_db, rise, fall, rpt, m_db, m_rise, m_fall, m_rpt);
                end
            end
        end
        pbtn_in[2] = 1'b0;
    endtask

    task automatic test_repeat();
        int hits[$];
        bit got = 0;
        bit got_fall = 0;
        rpt_en[3] = 1'b1;
        pbtn_in[3] = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (rise[3]) got = 1;
        end
        tests_run++;
        if (!got) begin
            fails++;
            $display("FAIL rpt_press: got no rise[3] want one within 30 cycles");
        end
        for (int i = 1; i <= 60; i++) begin
            step();
            tests_run++;
            if ({pbtn_db, rise, fall, rpt} !== {m_db, m_rise, m_fall, m_rpt}) begin
                fails++;
                $display("FAIL model_repeat: got %b/%b/%b/%b want %b/%b/%b/%b",
                         pbtn_db, rise, fall, rpt, m_db, m_rise, m_fall, m_rpt);
            end
            if (rpt[3]) hits.push_back(i);
        end
        tests_run++;
        if (hits.size() != 6) begin
            fails++;
            $display("FAIL rpt_count: got %0d pulses want 6", hits.size());
        end
        for (int k = 0; k < hits.size(); k++) begin
            tests_run++;
            if (hits[k] != 20 + 8 * k) begin
                fails++;
                $display("FAIL rpt_time: pulse %0d got cycle %0d want %0d", k, hits[k], 20 + 8 * k);
            end
        end
        pbtn_in[3] = 1'b0;
        for (int i = 0; i < 30 && !got_fall; i++) begin
            step();
            if (fall[3]) got_fall = 1;
        end
        tests_run++;
        if (!got_fall) begin
            fails++;
            $display("FAIL rpt_release: got no fall[3] want one within 30 cycles");
        end
        for (int i = 0; i < 30; i++) begin
            step();
            tests_run++;
            if (rpt[3] !== 1'b0) begin
                fails++;
                $display("FAIL rpt_after_fall: got rpt[3]=%b want 0", rpt[3]);
            end
        end
    endtask

    task automatic test_rpt_en_drop();
        bit got = 0;
        pbtn_in[3] = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            if (rpt[3]) got = 1;
        end
        tests_run++;
        if (!got) begin
            fails++;
            $display("FAIL en_first_rpt: got no rpt[3] want one within 60 cycles");
        end
        rpt_en[3] = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (i == 30) rpt_en[3] = 1'b1;
            step();
            tests_run++;
            if (rpt[3] !== 1'b0 || {pbtn_db, rise, fall, rpt} !== {m_db, m_rise, m_fall, m_rpt}) begin
                fails++;
                $display("FAIL en_drop: cyc %0d got %b/%b/%b/%b want %b/%b/%b/%b (rpt[3]=0)",
                         i, pbtn_db, rise, fall, rpt, m_db, m_rise, m_fall, m_rpt);
            end
        end
        pbtn_in[3] = 1'b0;
        rpt_en[3] = 1'b0;
        repeat (20) step();
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        bit got_rpt = 0;
        rpt_en = 6'b010010;
        pbtn_in[1] = 1'b1;
        pbtn_in[4] = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (rise[1] || rise[4]) begin
                got = 1;
                tests_run++;
                if (rise[1] !== 1'b1 || rise[4] !== 1'b1) begin
                    fails++;
                    $display("FAIL dual_rise: got rise=%b want bits 1 and 4 together", rise);
                end
            end
        end
        tests_run++;
        if (!got) begin
            fails++;
            $display("FAIL dual_press: got no rise want rise[1],rise[4] within 30 cycles");
        end
        repeat (8) step();
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({pbtn_db, rise, fall, rpt} !== {RV, 18'b0}) begin
            fails++;
            $display("FAIL async_reset: got db=%b r=%b f=%b p=%b want db=%b quiet",
                     pbtn_db, rise, fall, rpt, RV);
        end
        pbtn_in = RV;
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            tests_run++;
            if (rpt !== '0 || {pbtn_db, rise, fall, rpt} !== {m_db, m_rise, m_fall, m_rpt}) begin
                fails++;
                $display("FAIL post_reset: got %b/%b/%b/%b want %b/%b/%b/%b (rpt=0)",
                         pbtn_db, rise, fall, rpt, m_db, m_rise, m_fall, m_rpt);
            end
        end
        pbtn_in[4] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rpt[4]) got_rpt = 1;
        end
        tests_run++;
        if (!got_rpt) begin
            fails++;
            $display("FAIL fresh_press_rpt: got no rpt[4] want one after new press");
        end
        pbtn_in[4] = 1'b0;
        rpt_en = '0;
        repeat (20) step();
    endtask

    task automatic test_random();
        int hold_left[N];
        for (int c = 0; c < N; c++) hold_left[c] = $urandom_range(1, 30);
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++) begin
                hold_left[c]--;
                if (hold_left[c] <= 0) begin
                    pbtn_in[c] = ~pbtn_in[c];
                    hold_left[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3)
                                                               : $urandom_range(4, 60);
                end
                if ($urandom_range(0, 199) == 0) rpt_en[c] = ~rpt_en[c];
            end
            step();
            tests_run++;
            if ({pbtn_db, rise, fall, rpt} !== {m_db, m_rise, m_fall, m_rpt}) begin
                fails++;
                $display("FAIL model_random: cyc %0d got %b/%b/%b/%b want %b/%b/%b/%b",
                         i, pbtn_db, rise, fall, rpt, m_db, m_rise, m_fall, m_rpt);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_debounce_rise();
        test_glitch();
        test_repeat();
        test_rpt_en_drop();
        test_reset_mid();
        rpt_en = 6'b111110;
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/debounce_ar.md
Name: debounce_ar

Overview:
- Parametrised successor to the board-level pushbutton debouncer, covering N channels.
- Per channel: synchronises an asynchronous button, debounces it against a shared millisecond-scale tick, and emits the level, rise/fall pulses and hold-to-repeat pulses.
- Sits between the board button pins and the game/menu logic; the seven-segment and controller paths are unchanged.
- Per-channel reset value lets active-low buttons (CPU reset) come out of reset deasserted.

Parameters:
NUM_BTNS, 6, number of button channels
TICK_CYCLES, 100000, clk cycles per debounce tick (1 ms at 100 MHz)
DB_TICKS, 5, consecutive ticks of stable mismatch required to change a debounced level
RPT_DELAY_TICKS, 500, ticks from rise to first repeat pulse
RPT_PERIOD_TICKS, 100, ticks between subsequent repeat pulses
RESET_VAL, 6'b000001, per-channel reset value of pbtn_db (bit0 = active-low CPU reset button)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset
pbtn_in  in  NUM_BTNS  raw asynchronous button inputs
rpt_en  in  NUM_BTNS  per-channel auto-repeat enable
pbtn_db  out  NUM_BTNS  debounced level
rise  out  NUM_BTNS  1-cycle pulse when pbtn_db goes 0->1
fall  out  NUM_BTNS  1-cycle pulse when pbtn_db goes 1->0
rpt  out  NUM_BTNS  1-cycle auto-repeat pulse while held

Behaviour:
- Reset (reset=0, async):
  - pbtn_db=RESET_VAL; both synchroniser stages also =RESET_VAL.
  - rise, fall, rpt = 0; tick counter = 0; all debounce/repeat counters = 0; all FSMs = IDLE.
- Tick generator:
  - Free-running counter 0..TICK_CYCLES-1, shared by all channels.
  - tick=1 for the single cycle in which the counter equals TICK_CYCLES-1; the counter then wraps to 0.
- Synchroniser: 2 flops per channel; sync = pbtn_in delayed 2 cycles.
- Debounce, per channel (counter width $clog2(DB_TICKS+1)):
  - Any cycle with sync==pbtn_db: db_cnt clears to 0 immediately.
  - sync!=pbtn_db and tick: db_cnt increments.
  - When the increment makes db_cnt==DB_TICKS: pbtn_db takes sync in that same clock edge, and db_cnt clears.
  - Latency from a clean input edge to pbtn_db: between (DB_TICKS-1)*TICK_CYCLES+3 and DB_TICKS*TICK_CYCLES+2 cycles.
  - Glitches shorter than one tick never reach pbtn_db.
- Edge pulses:
  - rise/fall are registered and assert in the same cycle pbtn_db changes; high for exactly 1 cycle.
  - The reset-to-RESET_VAL transition never produces a pulse.
- Repeat FSM, per channel (states IDLE, HOLD, REPEAT; rpt_cnt width $clog2(max(RPT_DELAY_TICKS,RPT_PERIOD_TICKS)+1)):
  - IDLE -> HOLD on rise when rpt_en=1; rpt_cnt=0.
  - HOLD: rpt_cnt increments on tick.
    - Increment reaching RPT_DELAY_TICKS -> rpt=1 for that cycle, go REPEAT, rpt_cnt=0.
  - REPEAT: rpt_cnt increments on tick.
    - Increment reaching RPT_PERIOD_TICKS -> rpt=1, rpt_cnt=0, stay REPEAT.
  - HOLD/REPEAT -> IDLE, rpt_cnt=0, on fall or rpt_en=0.
    - Takes priority: if a repeat is due in the same cycle, no rpt is emitted.
  - rpt_en rising while the button is already held does not start repeat; only a new rise does.
  - rpt never coincides with rise.
- Channels are fully independent:
  - Simultaneous events on different channels are all reported in the same cycle.
  - Mid-operation reset aborts all counters and FSMs with no further pulses.
- Parameter legality: all *_TICKS >= 1, TICK_CYCLES >= 2; elaboration error otherwise.

Decomposition:
- Package debounce_pkg holds:
  - the repeat FSM state enum (IDLE/HOLD/REPEAT, 2 bits);
  - a width helper function for counter sizing.
- Sub-module debounce_chan contains the per-channel synchroniser, debounce counter, edge logic and repeat FSM; it is instantiated NUM_BTNS times via generate.
- Top holds the tick generator and the parameter checks.

Test Plan:
(bench params TICK_CYCLES=4, DB_TICKS=3, RPT_DELAY_TICKS=5, RPT_PERIOD_TICKS=2, NUM_BTNS=6, RESET_VAL=6'b000001)
1. Reset release with pbtn_in=6'b000001 -> pbtn_db=6'b000001 immediately; rise, fall, rpt stay 0 for 50 cycles.
2. pbtn_in[1] 0->1 held -> pbtn_db[1] rises within 11..14 cycles; rise[1] is high exactly 1 cycle, in the same cycle.
3. pbtn_in[2] pulse of 3 cycles, repeated every 6 cycles for 60 cycles -> pbtn_db[2] stays 0; no rise[2].
4. rpt_en[3]=1, press held for 60 cycles -> first rpt[3] 20 cycles after rise[3], then every 8 cycles; release -> fall[3] and no further rpt.
5. rpt_en[3] dropped while in REPEAT -> rpt stops at once; re-raising rpt_en while still held -> no rpt until a new press.
6. Press ch1 and ch4 together, assert reset mid-HOLD -> outputs return to reset values asynchronously; after release, no rpt pulse until fresh presses.
